// File: rtl/seq_arith_unit.sv
// Sequential signed MUL / DIV / NEG unit: shift-add multiply, restoring divide, sign fixup.
// Optional divide datapath is enabled by defining ARITH_DIV_EN.
module seq_arith_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_res_hi,
  output logic [WIDTH-1:0] o_res_lo,
  output logic             o_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_DIV = 2'b01, OP_NEG = 2'b10, OP_RSV = 2'b11} op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d, q_q, q_d, m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q_q, neg_q_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic             err_q, err_d;
  logic             reject;

  logic [WIDTH-1:0]   mag_a, mag_b, quot_fix;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] prod_fix;

  assign mag_a    = i_a[WIDTH-1] ? -i_a : i_a;
  assign mag_b    = i_b[WIDTH-1] ? -i_b : i_b;
  assign add_sum  = {1'b0, acc_q} + {1'b0, m_q};
  assign prod_fix = neg_q_q ? -{acc_q, q_q} : {acc_q, q_q};
  assign quot_fix = neg_q_q ? -q_q : q_q;

`ifdef ARITH_DIV_EN
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] sh_acc, rem_fix;
  logic [WIDTH:0]   trial;

  assign sh_acc  = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign trial   = {1'b0, sh_acc} - {1'b0, m_q};
  assign rem_fix = neg_r_q ? -acc_q : acc_q;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    q_d      = q_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    neg_q_d  = neg_q_q;
    ovf_d    = ovf_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    err_d    = err_q;
    reject   = 1'b0;
`ifdef ARITH_DIV_EN
    neg_r_d  = neg_r_q;
`endif
    unique case (state_q)
      IDLE: if (i_start) begin
        op_d    = op_t'(i_op);
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        neg_q_d = i_a[WIDTH-1] ^ i_b[WIDTH-1];
        case (op_t'(i_op))
          OP_MUL: begin
            q_d     = mag_b;
            m_d     = mag_a;
            state_d = RUN;
          end
`ifdef ARITH_DIV_EN
          OP_DIV: begin
            if (i_b == '0) begin
              reject = 1'b1;
            end else begin
              q_d     = mag_a;
              m_d     = mag_b;
              neg_r_d = i_a[WIDTH-1];
              ovf_d   = (i_a == MIN_VAL) && (i_b == '1);
              state_d = RUN;
            end
          end
`endif
          OP_NEG: begin
            q_d     = mag_a;
            neg_q_d = ~i_a[WIDTH-1];
            ovf_d   = (i_a == MIN_VAL);
            state_d = FIX;
          end
          default: reject = 1'b1;
        endcase
        // Rejected requests report immediately, bypassing the datapath.
        if (reject) begin
          res_hi_d = '0;
          res_lo_d = '0;
          err_d    = 1'b1;
          state_d  = DONE;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end
`ifdef ARITH_DIV_EN
        if (op_q == OP_DIV) begin
          acc_d = trial[WIDTH] ? sh_acc : trial[WIDTH-1:0];
          q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        end else
`endif
        if (q_q[0]) {acc_d, q_d} = {add_sum, q_q[WIDTH-1:1]};
        else        {acc_d, q_d} = {1'b0, acc_q, q_q[WIDTH-1:1]};
      end
      FIX: begin
        err_d   = ovf_q;
        state_d = DONE;
        case (op_q)
          OP_MUL: {res_hi_d, res_lo_d} = prod_fix;
`ifdef ARITH_DIV_EN
          OP_DIV: begin
            res_hi_d = rem_fix;
            res_lo_d = quot_fix;
          end
`endif
          default: begin
            res_hi_d = '0;
            res_lo_d = quot_fix;
          end
        endcase
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      acc_q    <= '0;
      q_q      <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      neg_q_q  <= 1'b0;
      ovf_q    <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      err_q    <= 1'b0;
`ifdef ARITH_DIV_EN
      neg_r_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      neg_q_q  <= neg_q_d;
      ovf_q    <= ovf_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      err_q    <= err_d;
`ifdef ARITH_DIV_EN
      neg_r_q  <= neg_r_d;
`endif
    end
  end

  assign o_busy   = (state_q != IDLE);
  assign o_done   = (state_q == DONE);
  assign o_res_hi = res_hi_q;
  assign o_res_lo = res_lo_q;
  assign o_err    = err_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Scoreboard bench for seq_arith_unit: integer reference model, decoupled done monitor.
// Follows ARITH_DIV_EN the same way the design does.
module tb_seq_arith_unit;
  localparam int W = 4;
`ifdef ARITH_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         i_rst_n, i_start;
  logic [1:0]   i_op;
  logic [W-1:0] i_a, i_b;
  logic         o_busy, o_done, o_err;
  logic [W-1:0] o_res_hi, o_res_lo;

  seq_arith_unit #(.WIDTH(W)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .o_busy(o_busy), .o_done(o_done),
    .o_res_hi(o_res_hi), .o_res_lo(o_res_lo), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         err;
    int           done_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return v[W-1] ? int'(v) - (1 << W) : int'(v);
  endfunction

  // Reference: plain integer arithmetic; latency counts the accepting edge as edge 1.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] hi, output logic [W-1:0] lo,
                       output logic err, output int lat);
    int ia, ib, p, q, r;
    ia = sx(a);
    ib = sx(b);
    hi = '0; lo = '0; err = 1'b1; lat = 1;
    if (op == 2'b00) begin
      p = ia * ib;
      {hi, lo} = p[2*W-1:0];
      err = 1'b0;
      lat = W + 2;
    end else if (op == 2'b01 && DIV_EN && ib != 0) begin
      q = ia / ib;
      r = ia % ib;
      lo  = q[W-1:0];
      hi  = r[W-1:0];
      err = (ia == -(1 << (W-1))) && (ib == -1);
      lat = W + 2;
    end else if (op == 2'b10) begin
      r   = -ia;
      lo  = r[W-1:0];
      err = (ia == -(1 << (W-1)));
      lat = 2;
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_done) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: o_done=1 with no outstanding operation (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.done_cyc);
          check("res_hi", o_res_hi, e.hi);
          check("res_lo", o_res_lo, e.lo);
          check("err", o_err, e.err);
          check("busy_at_done", o_busy, 1);
        end
      end
    end
  end

  // Issue one operation from an IDLE negedge; returns at the first IDLE negedge after DONE.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke);
    exp_t e;
    int   lat;
    model(op, a, b, e.hi, e.lo, e.err, lat);
    i_op = op; i_a = a; i_b = b; i_start = 1'b1;
    @(posedge clk);
    #1;
    e.done_cyc = cyc + lat - 1;
    sb.push_back(e);
    @(negedge clk);
    i_start = 1'b0;
    i_a = W'($urandom); i_b = W'($urandom); i_op = 2'($urandom);
    check("busy_after_accept", o_busy, 1);
    if (poke && lat > 2) begin
      @(negedge clk);
      i_start = 1'b1; i_op = 2'b00; i_a = W'($urandom); i_b = W'($urandom);
      @(negedge clk);
      i_start = 1'b0;
    end
    for (int k = 0; k < W + 8 && !o_done; k++) @(negedge clk);
    if (!o_done) begin
      n_total++;
      $display("FAIL done_timeout: o_done=0 after cycle budget, expected 1 (op=%0d)", op);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_op = '0; i_a = '0; i_b = '0;
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_hi", o_res_hi, 0);
    check("rst_lo", o_res_lo, 0);
    check("rst_err", o_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    i_rst_n = 1'b1;

    // Directed corner cases, back-to-back; the first also pokes i_start during RUN.
    run_op(2'b00, 4'b0110, 4'b1001, 1'b1);
    run_op(2'b01, 4'b1001, 4'b0010, 1'b0);
    run_op(2'b01, 4'b1000, 4'b1111, 1'b0);
    run_op(2'b01, 4'b0101, 4'b0000, 1'b0);
    run_op(2'b10, 4'b0110, 4'b0000, 1'b0);
    run_op(2'b10, 4'b1000, 4'b0000, 1'b0);
    run_op(2'b11, 4'b0011, 4'b0101, 1'b0);
    run_op(2'b00, 4'b1000, 4'b1000, 1'b0);
    run_op(2'b01, 4'b0111, 4'b1101, 1'b1);

    for (int n = 0; n < 80; n++)
      run_op(2'($urandom), W'($urandom), W'($urandom), ($urandom_range(0, 3) == 0));

    // Reset mid-RUN: outputs clear at once, no done pulse, then a clean MUL.
    run_op(2'b00, 4'b0111, 4'b0101, 1'b0);
    i_op = 2'b00; i_a = 4'b0101; i_b = 4'b0011; i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    i_rst_n = 1'b0;
    #1;
    check("midrst_busy", o_busy, 0);
    check("midrst_done", o_done, 0);
    check("midrst_hi", o_res_hi, 0);
    check("midrst_lo", o_res_lo, 0);
    check("midrst_err", o_err, 0);
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    check("post_rst_idle", o_busy, 0);
    run_op(2'b00, 4'b0011, 4'b0011, 1'b0);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_arith_unit.md
SEQ_ARITH_UNIT -- requirements
Module: seq_arith_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits (WIDTH >= 2).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_start, input, 1, operation request; sampled only in IDLE.
REQ-005 SHALL have port i_op, input, 2, operation select: 00 MUL, 01 DIV, 10 NEG (negate i_a), 11 reserved.
REQ-006 SHALL have ports i_a and i_b, input, WIDTH each, signed two's-complement operands.
REQ-007 SHALL have port o_busy, output, 1, high in every state except IDLE.
REQ-008 SHALL have port o_done, output, 1, one-cycle completion pulse.
REQ-009 SHALL have ports o_res_hi and o_res_lo, output, WIDTH each, result (MUL: product hi/lo; DIV: remainder/quotient; NEG: o_res_hi 0, o_res_lo result).
REQ-010 SHALL have port o_err, output, 1, error flag for the last completed operation.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-012 SHALL, on the edge where IDLE samples i_start=1, capture i_op and the operand magnitudes and the result sign, then enter RUN (MUL, DIV), FIX (NEG), or DONE (error cases, REQ-018).
REQ-013 SHALL, in RUN, perform one shift-add (MUL) or one restoring shift-subtract (DIV) step per cycle on magnitudes, using a WIDTH-bit accumulator and a WIDTH-bit Q register; exactly WIDTH cycles; then FIX.
REQ-014 SHALL, in FIX, apply sign correction in one cycle, then DONE; DONE lasts one cycle with o_done=1, then IDLE.
REQ-015 SHALL have latency: MUL/DIV o_done high WIDTH+2 edges after the accepting edge; NEG 2 edges; error cases 1 edge.
REQ-016 SHALL produce the full 2*WIDTH signed product for MUL; no overflow is possible, and o_err=0.
REQ-017 SHALL produce a quotient truncated toward zero for DIV, with the remainder taking the sign of the dividend.
REQ-018 SHALL, for DIV with i_b=0 or for i_op=11, set o_err=1 and o_res_hi=o_res_lo=0, skipping RUN and FIX.
REQ-019 SHALL, for DIV of -2^(WIDTH-1) by -1, set o_err=1, o_res_lo=-2^(WIDTH-1) (wrapped), and o_res_hi=0.
REQ-020 SHALL, for NEG of -2^(WIDTH-1), set o_err=1 and o_res_lo=-2^(WIDTH-1).
REQ-021 SHALL ignore i_start while o_busy=1; in-flight operands are unaffected by input changes after acceptance.
REQ-022 SHALL update o_res_hi, o_res_lo and o_err only on the edge entering DONE, and hold them until the next completion.
REQ-023 SHALL accept a new i_start in the cycle after DONE (back-to-back throughput of one operation per latency+1 cycles).

Reset
REQ-024 SHALL, while i_rst_n=0, force IDLE, o_busy=0, o_done=0, o_err=0, o_res_hi=0, o_res_lo=0, and internal accumulator, Q and counter to 0, independent of clk.
REQ-025 SHALL abort any in-flight operation on reset with no o_done pulse; after release, the first rising edge with i_start=1 is accepted.

Configuration
REQ-026 SHALL, with macro ARITH_DIV_EN defined, implement DIV per REQ-013/017/019.
REQ-027 SHALL, without ARITH_DIV_EN, omit all divide logic and treat i_op=01 as reserved per REQ-018 (err=1, results 0, 1-edge latency).

Verification (WIDTH=4)
REQ-028 SHALL verify MUL: i_a=0110 (6), i_b=1001 (-7) -> o_done at edge 6; o_res_hi=1101, o_res_lo=0110 (-42); o_err=0.
REQ-029 SHALL verify DIV (ARITH_DIV_EN): i_a=1001 (-7), i_b=0010 -> o_res_lo=1101 (-3), o_res_hi=1111 (-1), o_err=0; also 1000/1111 -> o_err=1, o_res_lo=1000.
REQ-030 SHALL verify DIV by zero: i_a=0101, i_b=0000 -> o_done at edge 1, o_err=1, results 0000/0000; the same response occurs for i_op=01 when built without ARITH_DIV_EN.
REQ-031 SHALL verify NEG: i_a=0110 -> o_res_lo=1010 at edge 2, o_err=0; i_a=1000 -> o_err=1, o_res_lo=1000.
REQ-032 SHALL verify that i_start pulsed with new operands during RUN is ignored and the first result is unchanged; an i_start the cycle after DONE is accepted.
REQ-033 SHALL verify that i_rst_n low for one cycle mid-RUN gives all outputs 0 immediately, no o_done, and that a following MUL 0011 x 0011 gives 0000/1001.
